// File: rtl/avr_pkg.sv
// Shared AVR definitions: timer flag bit positions, interrupt vector base and
// the interrupt sequencer state encoding.
package avr_pkg;

    localparam int unsigned TOV0_BIT  = 0;
    localparam int unsigned OCF0_BIT  = 1;
    localparam int unsigned TOV1_BIT  = 2;
    localparam int unsigned OCF1B_BIT = 3;
    localparam int unsigned OCF1A_BIT = 4;
    localparam int unsigned ICF1_BIT  = 5;
    localparam int unsigned TOV2_BIT  = 6;
    localparam int unsigned OCF2_BIT  = 7;

    localparam logic [7:0] VECTOR_BASE = 8'h08;

    typedef enum logic [1:0] {
        IDLE,
        PUSH_LO,
        PUSH_HI,
        VECTOR
    } irq_state_t;

    // Bit 7 maps to the lowest vector; each lower bit is two words further on.
    function automatic logic [7:0] vector_addr(input logic [2:0] idx);
        return VECTOR_BASE + {4'b0000, 3'd7 - idx, 1'b0};
    endfunction

endpackage

// File: rtl/interrupt_unit_if.sv
// Signal bundle between the interrupt unit and the timers / control unit /
// program memory. master is the interrupt unit side.
interface interrupt_unit_if #(
    parameter int unsigned PC_WIDTH = 14
);
    logic [7:0]          tifr;
    logic [7:0]          timsk;
    logic                global_enable;
    logic                instr_boundary;
    logic                reti_done;
    logic [PC_WIDTH-1:0] pc_current;
    logic                stack_ready;
    logic                stack_valid;
    logic [7:0]          stack_data;
    logic                hold;
    logic                pc_overwrite;
    logic [PC_WIDTH-1:0] pc_new;
    logic                clear_i;
    logic [7:0]          tifr_clear;
    logic                irq_pending;

    modport master (
        input  tifr, timsk, global_enable, instr_boundary, reti_done, pc_current, stack_ready,
        output stack_valid, stack_data, hold, pc_overwrite, pc_new, clear_i, tifr_clear,
               irq_pending
    );

    modport slave (
        output tifr, timsk, global_enable, instr_boundary, reti_done, pc_current, stack_ready,
        input  stack_valid, stack_data, hold, pc_overwrite, pc_new, clear_i, tifr_clear,
               irq_pending
    );
endinterface

// File: rtl/irq_priority_encoder.sv
// Picks the highest set bit of the pending flag set; bit 7 has top priority.
module irq_priority_encoder (
    input  logic [7:0] pending,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |pending;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_unit.sv
// Timer interrupt sequencer: accepts the highest-priority enabled flag at an
// instruction boundary, pushes the return PC (low byte first) and vectors.
module interrupt_unit
    import avr_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 14
) (
    input logic               sysClock,
    input logic               rst,
    interrupt_unit_if.master  bus
);

    logic [7:0] pending;
    logic       enc_valid;
    logic [2:0] enc_idx;
    logic       accept;

    irq_state_t          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                reti_block_q, reti_block_d;
    logic [15:0]         pc_ext;

    logic                stack_valid_q, stack_valid_d;
    logic [7:0]          stack_data_q, stack_data_d;
    logic                hold_q, hold_d;
    logic                pc_overwrite_q, pc_overwrite_d;
    logic [PC_WIDTH-1:0] pc_new_q, pc_new_d;
    logic                clear_i_q, clear_i_d;
    logic [7:0]          tifr_clear_q, tifr_clear_d;

    assign pending = bus.tifr & bus.timsk;

    irq_priority_encoder u_encoder (
        .pending (pending),
        .valid   (enc_valid),
        .idx     (enc_idx)
    );

    // A coincident reti_done also vetoes acceptance so one instruction runs after RETI.
    assign accept = bus.instr_boundary & bus.global_enable & enc_valid &
                    ~reti_block_q & ~bus.reti_done;

    always_comb begin
        reti_block_d = reti_block_q;
        if (bus.reti_done) begin
            reti_block_d = 1'b1;
        end else if (bus.instr_boundary) begin
            reti_block_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PUSH_LO;
                    idx_d   = enc_idx;
                    pc_d    = bus.pc_current;
                end
            end
            PUSH_LO: if (bus.stack_ready) state_d = PUSH_HI;
            PUSH_HI: if (bus.stack_ready) state_d = VECTOR;
            VECTOR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the unit registered.
    always_comb begin
        pc_ext         = 16'(pc_d);
        stack_valid_d  = 1'b0;
        stack_data_d   = 8'h00;
        hold_d         = 1'b0;
        pc_overwrite_d = 1'b0;
        pc_new_d       = '0;
        clear_i_d      = 1'b0;
        tifr_clear_d   = 8'h00;
        unique case (state_d)
            PUSH_LO: begin
                stack_valid_d = 1'b1;
                stack_data_d  = pc_ext[7:0];
                hold_d        = 1'b1;
            end
            PUSH_HI: begin
                stack_valid_d = 1'b1;
                stack_data_d  = pc_ext[15:8];
                hold_d        = 1'b1;
            end
            VECTOR: begin
                hold_d         = 1'b1;
                pc_overwrite_d = 1'b1;
                pc_new_d       = PC_WIDTH'(vector_addr(idx_d));
                clear_i_d      = 1'b1;
                tifr_clear_d   = 8'b1 << idx_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysClock or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= 3'd0;
            pc_q           <= '0;
            reti_block_q   <= 1'b0;
            stack_valid_q  <= 1'b0;
            stack_data_q   <= 8'h00;
            hold_q         <= 1'b0;
            pc_overwrite_q <= 1'b0;
            pc_new_q       <= '0;
            clear_i_q      <= 1'b0;
            tifr_clear_q   <= 8'h00;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            pc_q           <= pc_d;
            reti_block_q   <= reti_block_d;
            stack_valid_q  <= stack_valid_d;
            stack_data_q   <= stack_data_d;
            hold_q         <= hold_d;
            pc_overwrite_q <= pc_overwrite_d;
            pc_new_q       <= pc_new_d;
            clear_i_q      <= clear_i_d;
            tifr_clear_q   <= tifr_clear_d;
        end
    end

    assign bus.stack_valid  = stack_valid_q;
    assign bus.stack_data   = stack_data_q;
    assign bus.hold         = hold_q;
    assign bus.pc_overwrite = pc_overwrite_q;
    assign bus.pc_new       = pc_new_q;
    assign bus.clear_i      = clear_i_q;
    assign bus.tifr_clear   = tifr_clear_q;
    assign bus.irq_pending  = |pending;

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed bench for interrupt_unit; outputs are packed as
// {stack_valid, stack_data, hold, pc_overwrite, pc_new, clear_i, tifr_clear}.
module tb_interrupt_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    interrupt_unit_if #(.PC_WIDTH(14)) bus ();

    interrupt_unit #(.PC_WIDTH(14)) dut (
        .sysClock (clk),
        .rst      (rst),
        .bus      (bus)
    );

    logic [33:0] obs;
    assign obs = {bus.stack_valid, bus.stack_data, bus.hold, bus.pc_overwrite, bus.pc_new,
                  bus.clear_i, bus.tifr_clear};

    function automatic logic [33:0] o_lo(input logic [7:0] d);
        return {1'b1, d, 1'b1, 1'b0, 14'h0, 1'b0, 8'h00};
    endfunction

    function automatic logic [33:0] o_vec(input logic [13:0] v, input logic [7:0] c);
        return {1'b0, 8'h00, 1'b1, 1'b1, v, 1'b1, c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.tifr = 8'h00; bus.timsk = 8'h00; bus.global_enable = 1'b0;
        bus.instr_boundary = 1'b0; bus.reti_done = 1'b0; bus.pc_current = 14'h0;
        bus.stack_ready = 1'b0;
        rst = 1'b1;
        step(); step();
        vectors++;
        if (obs !== 34'h0) begin
            miscompares++; $display("FAIL reset_outputs obs=%h exp=%h", obs, 34'h0);
        end
        bus.tifr = 8'h03; bus.timsk = 8'h02; #1;
        vectors++;
        if (bus.irq_pending !== 1'b1) begin
            miscompares++; $display("FAIL irq_pending_set got=%b exp=1", bus.irq_pending);
        end
        bus.tifr = 8'h01; #1;
        vectors++;
        if (bus.irq_pending !== 1'b0) begin
            miscompares++; $display("FAIL irq_pending_masked got=%b exp=0", bus.irq_pending);
        end
        bus.tifr = 8'h00; bus.timsk = 8'h00;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [33:0] exp [4];
        exp[0] = o_lo(8'h34);
        exp[1] = {1'b1, 8'h12, 1'b1, 1'b0, 14'h0, 1'b0, 8'h00};
        exp[2] = o_vec(14'h016, 8'h01);
        exp[3] = 34'h0;
        bus.tifr = 8'h01; bus.timsk = 8'h01; bus.global_enable = 1'b1;
        bus.pc_current = 14'h1234; bus.stack_ready = 1'b1;
        bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (obs !== exp[k]) begin
                miscompares++; $display("FAIL single_N+%0d obs=%h exp=%h", k + 1, obs, exp[k]);
            end
            step();
        end
        bus.tifr = 8'h00;
    endtask

    task automatic test_priority();
        bus.tifr = 8'h15; bus.timsk = 8'hFF; bus.global_enable = 1'b1;
        bus.pc_current = 14'h0100; bus.stack_ready = 1'b1;
        bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
        step(); step();
        vectors++;
        if (obs !== o_vec(14'h00E, 8'h10)) begin
            miscompares++; $display("FAIL prio_ff obs=%h exp=%h", obs, o_vec(14'h00E, 8'h10));
        end
        step();
        bus.timsk = 8'h05;
        bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
        // Inputs change after acceptance; the captured flag must still be serviced.
        bus.tifr = 8'h80; bus.timsk = 8'hFF; bus.global_enable = 1'b0;
        step(); step();
        vectors++;
        if (obs !== o_vec(14'h012, 8'h04)) begin
            miscompares++; $display("FAIL prio_05_frozen obs=%h exp=%h", obs,
                                    o_vec(14'h012, 8'h04));
        end
        step();
        bus.tifr = 8'h00;
    endtask

    task automatic test_masking();
        bus.tifr = 8'hFF; bus.timsk = 8'h00; bus.global_enable = 1'b1; #1;
        vectors++;
        if (bus.irq_pending !== 1'b0) begin
            miscompares++; $display("FAIL mask_pending got=%b exp=0", bus.irq_pending);
        end
        bus.instr_boundary = 1'b1;
        step(); step();
        vectors++;
        if (obs !== 34'h0) begin
            miscompares++; $display("FAIL mask_no_accept obs=%h exp=%h", obs, 34'h0);
        end
        bus.timsk = 8'hFF; bus.global_enable = 1'b0; #1;
        vectors++;
        if (bus.irq_pending !== 1'b1) begin
            miscompares++; $display("FAIL ie_pending got=%b exp=1", bus.irq_pending);
        end
        step(); step();
        vectors++;
        if (obs !== 34'h0) begin
            miscompares++; $display("FAIL ie_no_accept obs=%h exp=%h", obs, 34'h0);
        end
        bus.instr_boundary = 1'b0; bus.tifr = 8'h00; bus.timsk = 8'h00;
        step();
    endtask

    task automatic test_backpressure();
        int pushes = 0;
        logic [33:0] e;
        bus.tifr = 8'h02; bus.timsk = 8'hFF; bus.global_enable = 1'b1;
        bus.pc_current = 14'h2ABC; bus.stack_ready = 1'b0;
        bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            bus.stack_ready = (k == 4 || k >= 7);
            bus.instr_boundary = (k == 2);
            if (k <= 4)      e = o_lo(8'hBC);
            else if (k <= 7) e = {1'b1, 8'h2A, 1'b1, 1'b0, 14'h0, 1'b0, 8'h00};
            else if (k == 8) e = o_vec(14'h014, 8'h02);
            else             e = 34'h0;
            #1;
            vectors++;
            if (obs !== e) begin
                miscompares++; $display("FAIL bp_N+%0d obs=%h exp=%h", k, obs, e);
            end
            if (bus.stack_valid && bus.stack_ready) pushes++;
            step();
        end
        bus.instr_boundary = 1'b0;
        vectors++;
        if (pushes != 2) begin
            miscompares++; $display("FAIL bp_push_count got=%0d exp=2", pushes);
        end
        bus.tifr = 8'h00; bus.stack_ready = 1'b1;
    endtask

    task automatic test_reti();
        bus.tifr = 8'h01; bus.timsk = 8'h01; bus.global_enable = 1'b1;
        bus.pc_current = 14'h0042; bus.stack_ready = 1'b1;
        bus.reti_done = 1'b1;
        step();
        bus.reti_done = 1'b0; bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
        vectors++;
        if (obs !== 34'h0) begin
            miscompares++; $display("FAIL reti_first_blocked obs=%h exp=%h", obs, 34'h0);
        end
        bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
        vectors++;
        if (obs !== o_lo(8'h42)) begin
            miscompares++; $display("FAIL reti_second_accepted obs=%h exp=%h", obs, o_lo(8'h42));
        end
        step(); step(); step();
        bus.reti_done = 1'b1; bus.instr_boundary = 1'b1;
        step();
        bus.reti_done = 1'b0;
        vectors++;
        if (obs !== 34'h0) begin
            miscompares++; $display("FAIL reti_coincident obs=%h exp=%h", obs, 34'h0);
        end
        step();
        vectors++;
        if (obs !== 34'h0) begin
            miscompares++; $display("FAIL reti_after_coincident obs=%h exp=%h", obs, 34'h0);
        end
        step();
        bus.instr_boundary = 1'b0;
        vectors++;
        if (obs !== o_lo(8'h42)) begin
            miscompares++; $display("FAIL reti_reaccept obs=%h exp=%h", obs, o_lo(8'h42));
        end
        step(); step(); step();
        bus.tifr = 8'h00;
    endtask

    task automatic test_reset_mid();
        bus.tifr = 8'h80; bus.timsk = 8'h80; bus.global_enable = 1'b1;
        bus.pc_current = 14'h0155; bus.stack_ready = 1'b1;
        bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 34'h0) begin
            miscompares++; $display("FAIL reset_mid_async obs=%h exp=%h", obs, 34'h0);
        end
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (obs !== 34'h0) begin
            miscompares++; $display("FAIL reset_mid_no_strobe obs=%h exp=%h", obs, 34'h0);
        end
        bus.instr_boundary = 1'b1;
        step();
        bus.instr_boundary = 1'b0;
        vectors++;
        if (obs !== o_lo(8'h55)) begin
            miscompares++; $display("FAIL reset_restart_lo obs=%h exp=%h", obs, o_lo(8'h55));
        end
        step(); step();
        vectors++;
        if (obs !== o_vec(14'h008, 8'h80)) begin
            miscompares++; $display("FAIL reset_restart_vec obs=%h exp=%h", obs,
                                    o_vec(14'h008, 8'h80));
        end
        step();
        bus.tifr = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_backpressure();
        test_reti();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
